// File: rtl/pc_fetch_stage.sv
// Program-counter register and instruction-fetch sequencer sitting after the next-PC mux.
// Fetches the word at pc over a req/ready handshake and presents it to decode with PC+4/branch candidates.
module pc_fetch_stage #(
  parameter int                  MEM_SIZE = 18,
  parameter logic [MEM_SIZE-1:0] RESET_PC = '0,
  parameter int                  INSTR_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MEM_SIZE-1:0] next_pc,
  input  logic [15:0]         imm16,
  input  logic                stall,
  input  logic                imem_ready,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                imem_req,
  output logic [MEM_SIZE-1:0] imem_addr,
  output logic [MEM_SIZE-1:0] pc,
  output logic [MEM_SIZE-1:0] add_4_addr,
  output logic [MEM_SIZE-1:0] branch_offset,
  output logic [INSTR_W-1:0]  instr,
  output logic                instr_valid,
  output logic                align_err
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                fetch_done;
  logic                advance;
  logic [MEM_SIZE-1:0] imm_bytes;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:    state_nxt = FETCH;
      FETCH:   if (imem_ready) state_nxt = EXEC;
      EXEC:    if (!stall)     state_nxt = FETCH;
      default: state_nxt = BOOT;
    endcase
  end

  // Output decode: the request is purely a function of state, so rst drops it immediately.
  always_comb begin
    imem_req   = 1'b0;
    fetch_done = 1'b0;
    advance    = 1'b0;
    unique case (state)
      FETCH: begin
        imem_req   = 1'b1;
        fetch_done = imem_ready;
      end
      EXEC:    advance = !stall;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      align_err   <= 1'b0;
    end else begin
      align_err <= 1'b0;
      if (fetch_done) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (advance) begin
        pc          <= {next_pc[MEM_SIZE-1:2], 2'b00};
        instr_valid <= 1'b0;
        align_err   <= |next_pc[1:0];
      end
    end
  end

  assign imem_addr  = pc;
  assign add_4_addr = pc + MEM_SIZE'(3'd4);

  // Word offset becomes a byte offset at 18 bits, then sign-extends/truncates to the PC width.
  assign imm_bytes     = MEM_SIZE'(signed'({imm16, 2'b00}));
  assign branch_offset = add_4_addr + imm_bytes;

endmodule
